// File: rtl/chan_err_sched.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | chan_err_sched: burst error-injection scheduler between encoder/decoder  |
// | Optional statistics counters: define CHAN_ERR_STATS_EN.  Revision: 1.0   |
// +--------------------------------------------------------------------------+
module chan_err_sched #(
  parameter int PERIOD_W = 8,
  parameter int BURST_W  = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                cfg_load,
  input  logic [PERIOD_W-1:0] cfg_period,
  input  logic [BURST_W-1:0]  cfg_burst,
  input  logic [PERIOD_W-1:0] cfg_offset,
  input  logic [1:0]          cfg_mask,
  input  logic                sym_valid_i,
  input  logic [1:0]          sym_i,
  output logic                sym_valid_o,
  output logic [1:0]          sym_o,
  output logic                inj_o,
  output logic [15:0]         sym_ct_o,
  output logic [15:0]         bad_bit_ct_o
);

  localparam int EFF_W = (PERIOD_W > BURST_W) ? PERIOD_W : BURST_W;

  typedef enum logic [1:0] {
    ST_DISABLED = 2'd0,
    ST_WAIT     = 2'd1,
    ST_BURST    = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [PERIOD_W-1:0] wait_ct_q, wait_ct_d;
  logic [BURST_W-1:0]  burst_ct_q, burst_ct_d;
  logic [PERIOD_W-1:0] period_q, period_d;
  logic [BURST_W-1:0]  burst_q, burst_d;
  logic [1:0]          mask_q, mask_d;
  logic                sym_valid_q, sym_valid_d;
  logic [1:0]          sym_q, sym_d;
  logic                inj_q, inj_d;

  logic                corrupt;
  logic [BURST_W-1:0]  eff_m1;

  // Burst never longer than the period, so eff-1 always fits in BURST_W bits.
  always_comb begin
    if (EFF_W'(burst_q) <= EFF_W'(period_q)) eff_m1 = burst_q - BURST_W'(1);
    else                                     eff_m1 = BURST_W'(period_q - PERIOD_W'(1));
  end

  always_comb begin
    state_d    = state_q;
    wait_ct_d  = wait_ct_q;
    burst_ct_d = burst_ct_q;
    period_d   = period_q;
    burst_d    = burst_q;
    mask_d     = mask_q;
    corrupt    = 1'b0;

    if (cfg_load) begin
      period_d   = cfg_period;
      burst_d    = cfg_burst;
      mask_d     = cfg_mask;
      wait_ct_d  = cfg_offset;
      burst_ct_d = '0;
      if ((cfg_period != '0) && (cfg_burst != '0) && (cfg_mask != 2'b00)) state_d = ST_WAIT;
      else                                                              state_d = ST_DISABLED;
    end else if (sym_valid_i) begin
      case (state_q)
        ST_WAIT, ST_BURST: begin
          if (wait_ct_q == '0) begin
            corrupt    = 1'b1;
            wait_ct_d  = period_q - PERIOD_W'(1);
            burst_ct_d = eff_m1;
            state_d    = (eff_m1 != '0) ? ST_BURST : ST_WAIT;
          end else if (state_q == ST_WAIT) begin
            wait_ct_d = wait_ct_q - PERIOD_W'(1);
          end else begin
            corrupt    = 1'b1;
            wait_ct_d  = wait_ct_q - PERIOD_W'(1);
            burst_ct_d = burst_ct_q - BURST_W'(1);
            if (burst_ct_q == BURST_W'(1)) state_d = ST_WAIT;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    sym_valid_d = sym_valid_i;
    inj_d       = sym_valid_i & corrupt;
    sym_d       = sym_q;
    if (sym_valid_i) sym_d = corrupt ? (sym_i ^ mask_q) : sym_i;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_DISABLED;
      wait_ct_q   <= '0;
      burst_ct_q  <= '0;
      period_q    <= '0;
      burst_q     <= '0;
      mask_q      <= 2'b00;
      sym_valid_q <= 1'b0;
      sym_q       <= 2'b00;
      inj_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      wait_ct_q   <= wait_ct_d;
      burst_ct_q  <= burst_ct_d;
      period_q    <= period_d;
      burst_q     <= burst_d;
      mask_q      <= mask_d;
      sym_valid_q <= sym_valid_d;
      sym_q       <= sym_d;
      inj_q       <= inj_d;
    end
  end

  assign sym_valid_o = sym_valid_q;
  assign sym_o       = sym_q;
  assign inj_o       = inj_q;

`ifdef CHAN_ERR_STATS_EN
  logic [15:0] sym_ct_q, sym_ct_d;
  logic [15:0] bad_bit_ct_q, bad_bit_ct_d;
  logic [1:0]  mask_pop;
  logic [16:0] bad_sum;

  always_comb begin
    mask_pop     = {1'b0, mask_q[1]} + {1'b0, mask_q[0]};
    bad_sum      = {1'b0, bad_bit_ct_q} + 17'(mask_pop);
    sym_ct_d     = sym_ct_q;
    bad_bit_ct_d = bad_bit_ct_q;
    if (cfg_load) begin
      sym_ct_d     = '0;
      bad_bit_ct_d = '0;
    end else if (sym_valid_i) begin
      if (sym_ct_q != 16'hFFFF) sym_ct_d = sym_ct_q + 16'd1;
      if (corrupt) bad_bit_ct_d = bad_sum[16] ? 16'hFFFF : bad_sum[15:0];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sym_ct_q     <= '0;
      bad_bit_ct_q <= '0;
    end else begin
      sym_ct_q     <= sym_ct_d;
      bad_bit_ct_q <= bad_bit_ct_d;
    end
  end

  assign sym_ct_o     = sym_ct_q;
  assign bad_bit_ct_o = bad_bit_ct_q;
`else
  assign sym_ct_o     = 16'h0000;
  assign bad_bit_ct_o = 16'h0000;
`endif

endmodule
`default_nettype wire
